// File: rtl/irq_daisy_ctrl.sv
// irq_daisy_ctrl: multi-channel daisy-chain interrupt source.
// Each channel is synchronised, optionally debounced and edge-detected into a
// pending register. The pending set competes for one chain position via IEI/IEO.
// IACK returns the serviced channel index, and RETI releases the chain.
module irq_daisy_ctrl #(
  parameter int N_CH     = 4,
  parameter int DEBOUNCE = 0,
  parameter int VEC_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in,
  input  logic [N_CH-1:0]  ie,
  input  logic             iei,
  output logic             ieo,
  output logic             irq,
  input  logic             iack,
  input  logic             reti,
  output logic [VEC_W-1:0] vec,
  output logic             vec_valid,
  output logic [N_CH-1:0]  pending
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]       state;
  logic [N_CH-1:0]  sync_a;
  logic [N_CH-1:0]  sync;
  logic [N_CH-1:0]  filt;
  logic [N_CH-1:0]  filt_d;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  sel_onehot;
  logic [N_CH-1:0]  clr;
  logic [VEC_W-1:0] sel_idx;
  logic             grant;

  // Two-flop synchroniser on every raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync   <= '0;
    end else begin
      sync_a <= in;
      sync   <= sync_a;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_nofilt
      assign filt = sync;
    end else begin : g_filt
      localparam int CW = $clog2(DEBOUNCE + 1);
      for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          filt_r;

        // Count consecutive cycles of disagreement; the filtered level adopts
        // the synchronised one on the cycle the count reaches DEBOUNCE.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            cnt    <= '0;
            filt_r <= 1'b0;
          end else if (sync[g] == filt_r) begin
            cnt <= '0;
          end else if (cnt == CW'(DEBOUNCE - 1)) begin
            cnt    <= '0;
            filt_r <= sync[g];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        assign filt[g] = filt_r;
      end
    end
  endgenerate

  // Delayed filtered level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) filt_d <= '0;
    else     filt_d <= filt;
  end

  assign rise = filt & ~filt_d;
  assign req  = pending & ie;

  // Lowest set request index wins (channel 0 is highest priority)
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (req[i-1]) sel_idx = VEC_W'(i - 1);
    end
    sel_onehot[sel_idx] = 1'b1;
  end

  assign grant = (state == REQ) && iei && (|req) && iack;
  assign clr   = grant ? sel_onehot : '0;

  // Pending register: a new enabled rise overrides a same-cycle acknowledge clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr) | (rise & ie);
  end

  // Chain state machine with service vector capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      vec_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((|req) && iei) state <= REQ;
        end
        REQ: begin
          if (!iei || (req == '0)) begin
            state <= IDLE;
          end else if (iack) begin
            state     <= SERVICE;
            vec       <= sel_idx;
            vec_valid <= 1'b1;
          end
        end
        SERVICE: begin
          if (reti) begin
            state     <= IDLE;
            vec_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign irq = (state == REQ) && iei;
  assign ieo = iei && (state == IDLE) && (req == '0);

endmodule
